ibniz_pixel_engine: RTL

- Parametrised, mode-selectable successor to the single-formula Ibniz pixel generators.
- Computes one pixel value V per accepted (T, X, Y) sample through a fixed 3-stage pipeline with valid tracking and stall.
- Mode changes are frame-aligned, so a frame never mixes formulas.
- Sits between the T/X/Y scan counters and the colour/palette stage of the video path.

---
 rtl/ibniz_pixel_engine_if.sv | 41 ++++
 rtl/ibniz_pixel_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibniz_pixel_engine_if.sv
// ----------------------------------------------------------------------------
// ibniz_pixel_engine_if
// Bundles the sample/mode inputs and pixel/mode outputs of ibniz_pixel_engine.
//   master : scan-counter side (drives ena, samples and mode requests)
//   slave  : the pixel engine itself
// Signals:
//   ena          global clock enable (0 freezes the engine)
//   in_valid     T_in/X_in/Y_in carry a sample this cycle
//   frame_start  sample is the first pixel of a frame
//   T_in/X_in/Y_in  signed time and coordinates, W bits
//   mode_sel     requested formula, mode_load captures it as pending
//   V_out        pixel value, out_valid marks a new pixel
//   mode_active  formula applied to incoming pixels
//   mode_pending a loaded formula waits for the next frame start
// ----------------------------------------------------------------------------
interface ibniz_pixel_engine_if #(
   parameter int W = 32
);
   logic                ena;
   logic                in_valid;
   logic                frame_start;
   logic signed [W-1:0] T_in;
   logic signed [W-1:0] X_in;
   logic signed [W-1:0] Y_in;
   logic [1:0]          mode_sel;
   logic                mode_load;
   logic signed [W-1:0] V_out;
   logic                out_valid;
   logic [1:0]          mode_active;
   logic                mode_pending;

   modport master (
      output ena, in_valid, frame_start, T_in, X_in, Y_in, mode_sel, mode_load,
      input  V_out, out_valid, mode_active, mode_pending
   );

   modport slave (
      input  ena, in_valid, frame_start, T_in, X_in, Y_in, mode_sel, mode_load,
      output V_out, out_valid, mode_active, mode_pending
   );
endinterface

// File: rtl/ibniz_pixel_engine.sv
// ----------------------------------------------------------------------------
// ibniz_pixel_engine
// Mode-selectable Ibniz pixel generator. Each accepted (T, X, Y) sample is
// turned into one pixel value V by a 3-stage pipeline:
//   stage 1 registers the sample together with its effective mode tag,
//   stage 2 forms two partial terms a/b according to the tag,
//   stage 3 combines a and b into V_out.
// Mode changes are frame aligned: a loaded mode is held pending until the
// next accepted frame_start sample, so one frame never mixes formulas.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  ibniz_pixel_engine_if.slave (ena, in_valid, frame_start, T_in, X_in,
//        Y_in, mode_sel, mode_load -> V_out, out_valid, mode_active,
//        mode_pending)
//
// Parameters: W (data width, >= 16), ROT (mode-0 rotate, 1..W-1),
//             FRAC (fractional bits of T).
//
// Build option: define IBNIZ_SAT_EN to make the mode-0 sum and the mode-1/2
// products saturate to the signed W-bit range instead of wrapping.
// ----------------------------------------------------------------------------
module ibniz_pixel_engine #(
   parameter int W    = 32,
   parameter int ROT  = 7,
   parameter int FRAC = 16
) (
   input logic                 clk,
   input logic                 rst,
   ibniz_pixel_engine_if.slave bus
);

   // -------------------------------------------------------------------------
   // Arithmetic helpers
   // -------------------------------------------------------------------------

   // Rotate right by ROT within W bits (done on the unsigned view).
   function automatic logic signed [W-1:0] rotr(input logic signed [W-1:0] v);
      logic [W-1:0] u;
      u = v;
      return $signed((u >> ROT) | (u << (W - ROT)));
   endfunction

   // ((x>>>4)*(y>>>4))>>>8 evaluated at full 2W precision, truncated to W.
   function automatic logic signed [W-1:0] scaled_product(
      input logic signed [W-1:0] x,
      input logic signed [W-1:0] y
   );
      logic signed [W-1:0]   xs;
      logic signed [W-1:0]   ys;
      logic signed [2*W-1:0] xe;
      logic signed [2*W-1:0] ye;
      logic signed [2*W-1:0] p;
      xs = x >>> 4;
      ys = y >>> 4;
      xe = {{W{xs[W-1]}}, xs};
      ye = {{W{ys[W-1]}}, ys};
      p  = xe * ye;
      p  = p >>> 8;
      return p[W-1:0];
   endfunction

   // Reduce a 2W-bit signed intermediate to the W-bit result: clamp to the
   // signed range when saturation is built in, otherwise keep the low bits.
   function automatic logic signed [W-1:0] fit_w(input logic signed [2*W-1:0] p);
      logic signed [W-1:0] r;
`ifdef IBNIZ_SAT_EN
      logic signed [2*W-1:0] hi;
      logic signed [2*W-1:0] lo;
      hi = $signed({{(W+1){1'b0}}, {(W-1){1'b1}}});
      lo = $signed({{(W+1){1'b1}}, {(W-1){1'b0}}});
      if (p > hi) begin
         r = $signed({1'b0, {(W-1){1'b1}}});
      end else if (p < lo) begin
         r = $signed({1'b1, {(W-1){1'b0}}});
      end else begin
         r = p[W-1:0];
      end
`else
      r = p[W-1:0];
`endif
      return r;
   endfunction

   // Final combine of the partial terms according to the pixel's mode tag.
   function automatic logic signed [W-1:0] combine(
      input logic [1:0]          tag,
      input logic signed [W-1:0] a,
      input logic signed [W-1:0] b
   );
      logic signed [2*W-1:0] ae;
      logic signed [2*W-1:0] be;
      logic signed [W-1:0]   r;
      ae = {{W{a[W-1]}}, a};
      be = {{W{b[W-1]}}, b};
      case (tag)
         2'd0:       r = fit_w(ae + be);
         2'd1, 2'd2: r = fit_w(ae * be);
         2'd3:       r = a ^ b;
         default:    r = '0;
      endcase
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]          mode_active_r;
   logic [1:0]          pend_mode_r;
   logic                mode_pending_r;

   logic                v1_r;
   logic [1:0]          tag1_r;
   logic signed [W-1:0] t1_r;
   logic signed [W-1:0] x1_r;
   logic signed [W-1:0] y1_r;

   logic                v2_r;
   logic [1:0]          tag2_r;
   logic signed [W-1:0] a2_r;
   logic signed [W-1:0] b2_r;

   logic                out_valid_r;
   logic signed [W-1:0] v_out_r;

   logic [1:0]          load_mode_s;
   logic                take_s;
   logic [1:0]          eff_mode_s;
   logic signed [W-1:0] a_s;
   logic signed [W-1:0] b_s;

   // Mode decision: a frame-start sample adopts the pending mode; a load in
   // the same cycle takes precedence so the freshly loaded mode applies.
   always_comb begin
      load_mode_s = pend_mode_r;
      take_s      = 1'b0;
      eff_mode_s  = mode_active_r;
      if (bus.mode_load) begin
         load_mode_s = bus.mode_sel;
      end else begin
         load_mode_s = pend_mode_r;
      end
      if (bus.ena && bus.in_valid && bus.frame_start &&
          (mode_pending_r || bus.mode_load)) begin
         take_s     = 1'b1;
         eff_mode_s = load_mode_s;
      end else begin
         take_s     = 1'b0;
         eff_mode_s = mode_active_r;
      end
   end

   // Pending/active mode registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_active_r  <= 2'd0;
         pend_mode_r    <= 2'd0;
         mode_pending_r <= 1'b0;
      end else if (bus.ena) begin
         pend_mode_r <= load_mode_s;
         if (take_s) begin
            mode_active_r  <= eff_mode_s;
            mode_pending_r <= 1'b0;
         end else if (bus.mode_load) begin
            mode_pending_r <= 1'b1;
         end
      end
   end

   // Stage 1: capture the accepted sample and its mode tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_r   <= 1'b0;
         tag1_r <= 2'd0;
         t1_r   <= '0;
         x1_r   <= '0;
         y1_r   <= '0;
      end else if (bus.ena) begin
         v1_r <= bus.in_valid;
         if (bus.in_valid) begin
            tag1_r <= eff_mode_s;
            t1_r   <= bus.T_in;
            x1_r   <= bus.X_in;
            y1_r   <= bus.Y_in;
         end
      end
   end

   // Stage 2 partial terms: a from the coordinates, b from time.
   always_comb begin
      a_s = '0;
      b_s = '0;
      case (tag1_r)
         2'd0: begin
            a_s = x1_r ^ y1_r;
            b_s = rotr(t1_r);
         end
         2'd1: begin
            a_s = scaled_product(x1_r, y1_r);
            b_s = t1_r >>> FRAC;
         end
         2'd2: begin
            a_s = x1_r & y1_r;
            b_s = t1_r >>> FRAC;
         end
         2'd3: begin
            a_s = x1_r + y1_r + (x1_r >>> 6);
            b_s = t1_r >>> FRAC;
         end
         default: begin
            a_s = '0;
            b_s = '0;
         end
      endcase
   end

   // Stage 2 registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_r   <= 1'b0;
         tag2_r <= 2'd0;
         a2_r   <= '0;
         b2_r   <= '0;
      end else if (bus.ena) begin
         v2_r <= v1_r;
         if (v1_r) begin
            tag2_r <= tag1_r;
            a2_r   <= a_s;
            b2_r   <= b_s;
         end
      end
   end

   // Stage 3: combine; V_out keeps its last value across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         v_out_r     <= '0;
      end else if (bus.ena) begin
         out_valid_r <= v2_r;
         if (v2_r) begin
            v_out_r <= combine(tag2_r, a2_r, b2_r);
         end
      end
   end

   assign bus.V_out        = v_out_r;
   assign bus.out_valid    = out_valid_r;
   assign bus.mode_active  = mode_active_r;
   assign bus.mode_pending = mode_pending_r;

endmodule
